pipe_bypass_chain: RTL and testbench

PIPE_BYPASS_CHAIN -- requirements
Module: pipe_bypass_chain

---
 rtl/pipe_bypass_chain_pkg.sv | 27 ++
 rtl/pipe_bypass_chain_if.sv | 16 +
 rtl/pipe_bypass_stage.sv | 46 ++++
 rtl/pipe_bypass_chain.sv | 105 ++++++++++
 tb/tb_pipe_bypass_chain.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_bypass_chain_pkg.sv
// Shared width definitions and stage-record layout for the bypass pipeline.
package pipe_bypass_chain_pkg;

  // Existing bus widths.
  localparam int BUS_DW = 32;

  // Bypass record field widths.
  localparam int REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;

  // Per-stage control record; the payload word lives beside it because its
  // width is a module parameter.
  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      rf_wen;
    logic      rdy;
  } stage_meta_t;

  // True when a stage occupant can forward to source register rs.
  // Register x0 never matches.
  function automatic logic fwd_match(input stage_meta_t m, input reg_addr_t rs);
    return m.valid && m.rf_wen && (m.rd == rs) && (rs != '0);
  endfunction

endpackage

// File: rtl/pipe_bypass_chain_if.sv
// Valid/allowin handshake bus carrying one pipeline entry.
import pipe_bypass_chain_pkg::*;

interface pipe_bypass_chain_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic             allowin;
  logic [WIDTH-1:0] data;
  reg_addr_t        rd;
  logic             rf_wen;
  logic             rdy;

  modport master (output valid, data, rd, rf_wen, rdy, input allowin);
  modport slave  (input valid, data, rd, rf_wen, rdy, output allowin);
endinterface

// File: rtl/pipe_bypass_stage.sv
// One pipeline stage: occupant register, allowin term and late-result capture.
module pipe_bypass_stage
  import pipe_bypass_chain_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  stage_meta_t      up_meta,
  input  logic [WIDTH-1:0] up_data,
  input  logic             load_fill,
  input  logic [WIDTH-1:0] fill_data,
  input  logic             down_allowin,
  input  logic             flush_self,
  output stage_meta_t      meta,
  output logic [WIDTH-1:0] data,
  output logic             allowin
);

  stage_meta_t      meta_reg;
  logic [WIDTH-1:0] data_reg;

  // An empty stage always accepts, so bubbles collapse.
  assign allowin = !meta_reg.valid || down_allowin;
  assign meta    = meta_reg;
  assign data    = data_reg;

  // Load from upstream when allowed, otherwise hold (a kill only clears valid).
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_reg <= '0;
      data_reg <= '0;
    end else if (allowin) begin
      meta_reg <= up_meta;
      if (load_fill) begin
        data_reg     <= fill_data;
        meta_reg.rdy <= 1'b1;
      end else begin
        data_reg <= up_data;
      end
    end else begin
      meta_reg.valid <= meta_reg.valid & !flush_self;
    end
  end

endmodule

// File: rtl/pipe_bypass_chain.sv
// Elastic result pipeline with per-stage kill, late-result fill and
// youngest-first register forwarding for two source queries.
module pipe_bypass_chain
  import pipe_bypass_chain_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4,
  parameter int READY_STAGE = 2
) (
  input  logic                clk,
  input  logic                reset,
  pipe_bypass_chain_if.slave  in_bus,
  pipe_bypass_chain_if.master out_bus,
  input  logic [WIDTH-1:0]    fill_data,
  input  logic [DEPTH-1:0]    flush,
  input  reg_addr_t           q_rs1,
  input  reg_addr_t           q_rs2,
  output logic                q1_hit,
  output logic [WIDTH-1:0]    q1_data,
  output logic                q1_stall,
  output logic                q2_hit,
  output logic [WIDTH-1:0]    q2_data,
  output logic                q2_stall,
  output logic [DEPTH-1:0]    stage_valid
);

  stage_meta_t      meta_w    [DEPTH];
  logic [WIDTH-1:0] data_w    [DEPTH];
  stage_meta_t      up_meta_w [DEPTH];
  logic [WIDTH-1:0] up_data_w [DEPTH];
  logic [DEPTH-1:0] load_fill_w;
  logic [DEPTH:0]   allowin_w;

  assign allowin_w[DEPTH] = out_bus.allowin;
  assign in_bus.allowin   = allowin_w[0];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign up_meta_w[gi] = '{valid:  in_bus.valid,
                                 rd:     in_bus.rd,
                                 rf_wen: in_bus.rf_wen,
                                 rdy:    in_bus.rdy};
        assign up_data_w[gi] = in_bus.data;
      end else begin : g_body
        // A killed occupant moves on as a bubble.
        assign up_meta_w[gi] = '{valid:  meta_w[gi-1].valid & !flush[gi-1],
                                 rd:     meta_w[gi-1].rd,
                                 rf_wen: meta_w[gi-1].rf_wen,
                                 rdy:    meta_w[gi-1].rdy};
        assign up_data_w[gi] = data_w[gi-1];
      end

      // Only a live, not-yet-ready entry entering the fill stage takes fill_data.
      assign load_fill_w[gi] = (gi == READY_STAGE) && up_meta_w[gi].valid && !up_meta_w[gi].rdy;

      pipe_bypass_stage #(
        .WIDTH (WIDTH)
      ) u_stage (
        .clk          (clk),
        .reset        (reset),
        .up_meta      (up_meta_w[gi]),
        .up_data      (up_data_w[gi]),
        .load_fill    (load_fill_w[gi]),
        .fill_data    (fill_data),
        .down_allowin (allowin_w[gi+1]),
        .flush_self   (flush[gi]),
        .meta         (meta_w[gi]),
        .data         (data_w[gi]),
        .allowin      (allowin_w[gi])
      );

      assign stage_valid[gi] = meta_w[gi].valid;
    end
  endgenerate

  assign out_bus.valid  = meta_w[DEPTH-1].valid;
  assign out_bus.data   = data_w[DEPTH-1];
  assign out_bus.rd     = meta_w[DEPTH-1].rd;
  assign out_bus.rf_wen = meta_w[DEPTH-1].rf_wen;
  assign out_bus.rdy    = meta_w[DEPTH-1].rdy;

  // Forwarding mux: scan oldest to youngest so the youngest match overrides.
  always_comb begin
    q1_hit   = 1'b0;
    q1_data  = '0;
    q1_stall = 1'b0;
    q2_hit   = 1'b0;
    q2_data  = '0;
    q2_stall = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (fwd_match(meta_w[i], q_rs1)) begin
        q1_hit   = 1'b1;
        q1_data  = data_w[i];
        q1_stall = !meta_w[i].rdy;
      end
      if (fwd_match(meta_w[i], q_rs2)) begin
        q2_hit   = 1'b1;
        q2_data  = data_w[i];
        q2_stall = !meta_w[i].rdy;
      end
    end
  end

endmodule

// File: tb/tb_pipe_bypass_chain.sv
// Directed scenarios plus randomized traffic checked against a slot-list model.
module tb_pipe_bypass_chain;
  import pipe_bypass_chain_pkg::*;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int RS = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [W-1:0]    fill_data;
  logic [D-1:0]    flush;
  reg_addr_t       q_rs1, q_rs2;
  logic            q1_hit, q1_stall, q2_hit, q2_stall;
  logic [W-1:0]    q1_data, q2_data;
  logic [D-1:0]    stage_valid;

  always #5 clk = ~clk;

  pipe_bypass_chain_if #(.WIDTH(W)) in_bus ();
  pipe_bypass_chain_if #(.WIDTH(W)) out_bus ();

  pipe_bypass_chain #(.WIDTH(W), .DEPTH(D), .READY_STAGE(RS)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_bus      (in_bus),
    .out_bus     (out_bus),
    .fill_data   (fill_data),
    .flush       (flush),
    .q_rs1       (q_rs1),
    .q_rs2       (q_rs2),
    .q1_hit      (q1_hit),
    .q1_data     (q1_data),
    .q1_stall    (q1_stall),
    .q2_hit      (q2_hit),
    .q2_data     (q2_data),
    .q2_stall    (q2_stall),
    .stage_valid (stage_valid)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: the occupant list, slot 0 youngest.
  logic         mv [D];
  logic [W-1:0] md [D];
  logic [4:0]   mr [D];
  logic         mw [D];
  logic         my [D];

  typedef struct {
    logic [W-1:0] d;
    int           c;
  } ent_t;
  ent_t         sb[$];
  logic [W-1:0] exits[$];
  bit           track_on = 1'b0;
  int           first_exit, last_exit;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [D:0] m_allow();
    logic [D:0] a;
    a[D] = out_bus.allowin;
    for (int i = D - 1; i >= 0; i--) a[i] = !mv[i] || a[i+1];
    return a;
  endfunction

  function automatic void m_query(input logic [4:0] rs, output logic hit,
                                  output logic [W-1:0] d, output logic st);
    hit = 1'b0; d = '0; st = 1'b0;
    for (int i = 0; i < D; i++) begin
      if (!hit && mv[i] && mw[i] && mr[i] == rs && rs != 5'd0) begin
        hit = 1'b1; d = md[i]; st = !my[i];
      end
    end
  endfunction

  task automatic m_clear();
    for (int i = 0; i < D; i++) begin
      mv[i] = 1'b0; md[i] = '0; mr[i] = '0; mw[i] = 1'b0; my[i] = 1'b0;
    end
  endtask

  task automatic check_all();
    logic [D:0]   a;
    logic [D-1:0] sv;
    logic         h, s;
    logic [W-1:0] d;
    a = m_allow();
    for (int i = 0; i < D; i++) sv[i] = mv[i];
    chk("stage_valid", stage_valid, sv);
    chk("in_allowin", in_bus.allowin, a[0]);
    chk("out_valid", out_bus.valid, mv[D-1]);
    if (mv[D-1]) begin
      chk("out_data", out_bus.data, md[D-1]);
      chk("out_rd", out_bus.rd, mr[D-1]);
      chk("out_rf_wen", out_bus.rf_wen, mw[D-1]);
    end
    m_query(q_rs1, h, d, s);
    chk("q1_hit", q1_hit, h);
    chk("q1_data", q1_data, d);
    chk("q1_stall", q1_stall, s);
    m_query(q_rs2, h, d, s);
    chk("q2_hit", q2_hit, h);
    chk("q2_data", q2_data, d);
    chk("q2_stall", q2_stall, s);
  endtask

  // One clock: check current outputs, log exits, advance the model and the DUT.
  task automatic step();
    logic [D:0]   a;
    logic         nv [D];
    logic [W-1:0] nd [D];
    logic [4:0]   nr [D];
    logic         nw [D];
    logic         ny [D];
    ent_t         e;
    #1;
    check_all();
    a = m_allow();
    if (out_bus.valid && out_bus.allowin && reset) begin
      $display("exit  cyc=%0d data=%08h rd=%0d wen=%0b", cyc, out_bus.data, out_bus.rd, out_bus.rf_wen);
      exits.push_back(out_bus.data);
      if (track_on) begin
        if (sb.size() == 0) begin
          chk("stream_unexpected_exit", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("stream_latency", cyc - e.c, D);
          chk("stream_order", out_bus.data, e.d);
          if (first_exit < 0) first_exit = cyc;
          last_exit = cyc;
        end
      end
    end
    if (track_on && in_bus.valid && a[0] && reset) begin
      e.d = in_bus.data; e.c = cyc;
      sb.push_back(e);
    end
    for (int i = 0; i < D; i++) begin
      if (a[i]) begin
        if (i == 0) begin
          nv[i] = in_bus.valid; nd[i] = in_bus.data; nr[i] = in_bus.rd;
          nw[i] = in_bus.rf_wen; ny[i] = in_bus.rdy;
        end else begin
          nv[i] = mv[i-1] && !flush[i-1]; nd[i] = md[i-1]; nr[i] = mr[i-1];
          nw[i] = mw[i-1]; ny[i] = my[i-1];
        end
        if (i == RS && nv[i] && !ny[i]) begin
          nd[i] = fill_data; ny[i] = 1'b1;
        end
      end else begin
        nv[i] = mv[i] && !flush[i]; nd[i] = md[i]; nr[i] = mr[i];
        nw[i] = mw[i]; ny[i] = my[i];
      end
    end
    @(posedge clk);
    cyc++;
    if (!reset) begin
      m_clear();
    end else begin
      for (int i = 0; i < D; i++) begin
        mv[i] = nv[i]; md[i] = nd[i]; mr[i] = nr[i]; mw[i] = nw[i]; my[i] = ny[i];
      end
    end
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [W-1:0] d, input logic [4:0] rd,
                          input logic wen, input logic rdy);
    in_bus.valid = v; in_bus.data = d; in_bus.rd = rd; in_bus.rf_wen = wen; in_bus.rdy = rdy;
  endtask

  initial begin
    reset = 1'b0;
    fill_data = '0;
    flush = '0;
    q_rs1 = '0;
    q_rs2 = '0;
    out_bus.allowin = 1'b1;
    drive_in(1'b0, '0, '0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    m_clear();
    reset = 1'b1;

    // Post-reset state.
    #1;
    chk("rst_out_valid", out_bus.valid, 1'b0);
    chk("rst_stage_valid", stage_valid, 4'b0000);
    chk("rst_in_allowin", in_bus.allowin, 1'b1);
    chk("rst_out_data", out_bus.data, 32'h0);
    chk("rst_q_hits", {q1_hit, q2_hit, q1_stall, q2_stall}, 4'b0000);

    // Stream 8 entries back to back.
    track_on = 1'b1; first_exit = -1; last_exit = -1;
    for (int k = 0; k < 8; k++) begin
      drive_in(1'b1, $urandom, 5'($urandom_range(1, 31)), 1'b1, 1'b1);
      step();
    end
    drive_in(1'b0, '0, '0, 1'b0, 1'b1);
    repeat (5) step();
    track_on = 1'b0;
    chk("stream_all_exited", sb.size(), 0);
    chk("stream_no_gaps", last_exit - first_exit, 7);

    // Fill, stall three cycles, then drain.
    out_bus.allowin = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_in(1'b1, 32'hA0 + 32'(k), 5'd1, 1'b1, 1'b1);
      step();
    end
    drive_in(1'b1, 32'hEE, 5'd1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_in_allowin", in_bus.allowin, 1'b0);
      chk("stall_head_data", out_bus.data, 32'hA0);
      chk("stall_full", stage_valid, 4'b1111);
      step();
    end
    drive_in(1'b0, '0, '0, 1'b0, 1'b1);
    out_bus.allowin = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("drain_valid", out_bus.valid, 1'b1);
      chk("drain_data", out_bus.data, 32'hA0 + 32'(k));
      step();
    end

    // Youngest match wins; x0 never forwards.
    out_bus.allowin = 1'b0;
    drive_in(1'b1, 32'h22, 5'd5, 1'b1, 1'b1); step();
    drive_in(1'b1, 32'h33, 5'd9, 1'b1, 1'b1); step();
    drive_in(1'b1, 32'h11, 5'd5, 1'b1, 1'b1); step();
    drive_in(1'b1, 32'h44, 5'd0, 1'b1, 1'b1); step();
    drive_in(1'b0, '0, '0, 1'b0, 1'b1);
    q_rs1 = 5'd5; q_rs2 = 5'd9;
    #1;
    chk("fwd_young_hit", q1_hit, 1'b1);
    chk("fwd_young_data", q1_data, 32'h11);
    chk("fwd_q2_data", q2_data, 32'h33);
    q_rs1 = 5'd0;
    #1;
    chk("fwd_x0_hit", q1_hit, 1'b0);
    step();
    out_bus.allowin = 1'b1;
    repeat (4) step();

    // Late result captured on entry to the fill stage.
    q_rs2 = 5'd7;
    drive_in(1'b1, 32'h1234, 5'd7, 1'b1, 1'b0);
    step();
    drive_in(1'b0, '0, '0, 1'b0, 1'b1);
    #1;
    chk("fill_s0_stall", q2_stall, 1'b1);
    chk("fill_s0_hit", q2_hit, 1'b1);
    step();
    fill_data = 32'hDEAD;
    #1;
    chk("fill_s1_stall", q2_stall, 1'b1);
    step();
    fill_data = '0;
    #1;
    chk("fill_s2_data", q2_data, 32'hDEAD);
    chk("fill_s2_stall", q2_stall, 1'b0);
    repeat (3) step();

    // Kill the stage-1 occupant while three entries are in flight.
    exits.delete();
    for (int k = 0; k < 3; k++) begin
      drive_in(1'b1, 32'h51 + 32'(k), 5'd2, 1'b1, 1'b1);
      step();
    end
    drive_in(1'b0, '0, '0, 1'b0, 1'b1);
    flush = 4'b0010;
    step();
    flush = '0;
    repeat (5) step();
    chk("flush_exit_count", exits.size(), 2);
    if (exits.size() == 2) begin
      chk("flush_exit0", exits[0], 32'h51);
      chk("flush_exit1", exits[1], 32'h53);
    end

    // Reset with entries in flight.
    for (int k = 0; k < 3; k++) begin
      drive_in(1'b1, 32'h61 + 32'(k), 5'd3, 1'b1, 1'b1);
      step();
    end
    drive_in(1'b0, '0, '0, 1'b0, 1'b1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    chk("midrst_stage_valid", stage_valid, 4'b0000);
    chk("midrst_in_allowin", in_bus.allowin, 1'b1);
    exits.delete();
    repeat (6) step();
    chk("midrst_no_exit", exits.size(), 0);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      drive_in(($urandom % 4) != 0, $urandom, 5'($urandom % 8), 1'($urandom), 1'($urandom));
      fill_data = $urandom;
      flush = (($urandom % 6) == 0) ? 4'($urandom) : 4'b0000;
      out_bus.allowin = ($urandom % 4) != 0;
      q_rs1 = 5'($urandom % 8);
      q_rs2 = 5'($urandom % 8);
      reset = (($urandom % 100) == 0) ? 1'b0 : 1'b1;
      step();
    end
    reset = 1'b1;
    drive_in(1'b0, '0, '0, 1'b0, 1'b1);
    flush = '0;
    out_bus.allowin = 1'b1;
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
